bound_scheduler: RTL and testbench
==================================

BOUND_SCHEDULER -- requirements
Module: bound_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the LED bar (2..8).
REQ-002 SHALL have parameter STEP_DIV, default 1, clock cycles per LED step (1..256).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  N_REQ  level request per requester, held until grant.
REQ-006 SHALL have port bound  input  4*N_REQ  requester i target bound at bits [4i+3:4i], 0..15.
REQ-007 SHALL have port kick  input  1  re-climb request during fall, meaningful only with BOUND_SCHED_KICKBACK_EN.
REQ-008 SHALL have port grant  output  N_REQ  one-hot, one-cycle pulse, request accepted and bound latched.
REQ-009 SHALL have port done  output  N_REQ  one-hot, one-cycle pulse, granted sweep finished.
REQ-010 SHALL have port busy  output  1  high while a sweep is in UP or DOWN.
REQ-011 SHALL have port LED  output  16  thermometer bar, level L means LED[L-1:0] on.

Function
REQ-012 SHALL implement states IDLE, UP, DOWN; the bar level is held in a 5-bit counter, 0..16.
REQ-013 In IDLE with any req bit high, the edge SHALL select one requester round-robin, latch its bound into B, enter UP with level 0, and register grant for exactly the following cycle.
REQ-014 Round-robin SHALL start the search at the index after the last granted requester, and at requester 0 after reset.
REQ-015 A step tick SHALL fire every STEP_DIV cycles, and the prescaler SHALL restart on each grant so that the first step occurs STEP_DIV cycles after the grant edge.
REQ-016 In UP, each tick SHALL increment level; when level reaches B+1, the state SHALL become DOWN on that same edge.
REQ-017 In DOWN, each tick SHALL decrement level; when level reaches 0, the state SHALL become IDLE and done for the granted index SHALL pulse in the cycle LED first reads 0.
REQ-018 The sweep SHALL take exactly 2*(B+1) ticks; B=0 lights only LED[0]; B=15 lights the full bar.
REQ-019 Arbitration SHALL be evaluated in the IDLE cycle where done is high, so a pending request receives grant in the cycle immediately after done.
REQ-020 req changes during UP/DOWN SHALL be ignored, and bound SHALL be sampled only at the grant edge.
REQ-021 A req bit dropped before grant SHALL be silently abandoned, with no grant and no done.
REQ-022 busy SHALL equal (state != IDLE), and grant and done SHALL never both be high for the same index in one cycle.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, level 0, LED=16'h0000, grant=0, done=0, busy=0, prescaler=0, RR pointer to requester 0.
REQ-024 Reset mid-sweep SHALL abort with no done pulse, and requests sampled while rst_n is low SHALL be ignored.
REQ-025 After rst_n rises, the first edge with req set SHALL be arbitrated normally.

Configuration
REQ-026 With macro BOUND_SCHED_KICKBACK_EN defined, kick high at a DOWN tick edge SHALL make that step an increment and return the state to UP, climbing again to B+1.
REQ-027 With BOUND_SCHED_KICKBACK_EN undefined, kick SHALL be ignored in every state, and the port SHALL remain present.
REQ-028 kick in IDLE or UP SHALL be ignored in both builds.

Structure
REQ-029 Package bound_sched_pkg SHALL hold the state enum (IDLE/UP/DOWN), LED_W=16, BOUND_W=4, and LEVEL_W=5.
REQ-030 Round-robin selection SHALL be sub-module rr_arbiter (req vector, pointer in; one-hot grant, index out, purely combinational).

Verification
REQ-031 STEP_DIV=1, req[2]=1, bound[2]=3 -> grant[2] one cycle, then LED 0001,0003,0007,000F,0007,0003,0001,0000, with done[2] on the 0000 cycle.
REQ-032 req=4'b1111 all bound=0 from reset -> grants in order 0,1,2,3, each sweep LED 0001 then 0000, each next grant the cycle after the prior done.
REQ-033 Bound=15, STEP_DIV=4 -> LED reaches FFFF 64 cycles after grant, busy is high for 128 cycles, then done.
REQ-034 rst_n low while LED=00FF in DOWN -> LED=0000 and busy=0 immediately, no done, and a re-request after release is granted normally.
REQ-035 KICKBACK_EN build, bound=5, kick at the DOWN tick with level 3 -> level 4 then climbs to 6 before falling; non-KICKBACK build with the same stimulus -> level 2.
REQ-036 req[1] raised during an active sweep of req[0] with bound[1] changed mid-wait -> grant[1] the cycle after done[0], with the bound value present at the grant edge used.

Source files
------------

// File: rtl/bound_sched_pkg.sv
// Shared types and widths for the bound scheduler LED sweep engine.
package bound_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam int LED_W   = 16;
    localparam int BOUND_W = 4;
    localparam int LEVEL_W = 5;

    // Thermometer decode: level L lights bits [L-1:0].
    function automatic logic [LED_W-1:0] therm(input logic [LEVEL_W-1:0] lvl);
        logic [LED_W-1:0] t;
        t = '0;
        for (int i = 0; i < LED_W; i++) begin
            t[i] = (LEVEL_W'(i) < lvl);
        end
        return t;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bound_scheduler.sv
// Shares one LED bar among N_REQ requesters: each grant sweeps the bar up to bound+1 and back.
// Optional re-climb on kick during the fall is enabled by defining BOUND_SCHED_KICKBACK_EN.
module bound_scheduler
    import bound_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [BOUND_W*N_REQ-1:0]   bound,
    input  logic                       kick,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           done,
    output logic                       busy,
    output logic [LED_W-1:0]           LED
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    state_t               state;
    logic [LEVEL_W-1:0]   level;
    logic [BOUND_W-1:0]   b;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        owner;
    logic [PW-1:0]        presc;

    logic [N_REQ-1:0]     arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic [BOUND_W-1:0]   sel_bound;
    logic [IW-1:0]        ptr_next;
    logic                 tick;
    logic                 kick_en;
    logic [LEVEL_W-1:0]   peak;
    logic [LEVEL_W-1:0]   lvl_inc;
    logic [LEVEL_W-1:0]   lvl_dec;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

`ifdef BOUND_SCHED_KICKBACK_EN
    assign kick_en = kick;
`else
    logic unused_kick;
    assign unused_kick = kick;
    assign kick_en     = 1'b0;
`endif

    assign sel_bound = bound[int'(arb_idx)*BOUND_W +: BOUND_W];
    assign ptr_next  = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
    assign tick      = (presc == PW'(STEP_DIV - 1));
    assign peak      = LEVEL_W'(b) + LEVEL_W'(1);
    assign lvl_inc   = level + LEVEL_W'(1);
    assign lvl_dec   = level - LEVEL_W'(1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            level <= '0;
            LED   <= '0;
            b     <= '0;
            ptr   <= '0;
            owner <= '0;
            presc <= '0;
            grant <= '0;
            done  <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            case (state)
                IDLE: begin
                    presc <= '0;
                    if (|req) begin
                        state <= UP;
                        level <= '0;
                        LED   <= '0;
                        b     <= sel_bound;
                        owner <= arb_idx;
                        ptr   <= ptr_next;
                        grant <= arb_gnt;
                    end
                end
                UP: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        level <= lvl_inc;
                        LED   <= therm(lvl_inc);
                        if (lvl_inc == peak) begin
                            state <= DOWN;
                        end
                    end
                end
                DOWN: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        // A kick at the peak itself has nowhere higher to go, so it falls normally.
                        if (kick_en && (level != peak)) begin
                            level <= lvl_inc;
                            LED   <= therm(lvl_inc);
                            if (lvl_inc != peak) begin
                                state <= UP;
                            end
                        end else begin
                            level <= lvl_dec;
                            LED   <= therm(lvl_dec);
                            if (lvl_dec == '0) begin
                                state <= IDLE;
                                done  <= N_REQ'(1) << owner;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    level <= '0;
                    LED   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bound_scheduler.sv
// Directed bench for bound_scheduler: one instance at STEP_DIV=1, one at STEP_DIV=4.
module tb_bound_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req1, grant1, done1;
    logic [15:0] bound1, led1;
    logic        kick1, busy1;

    logic [3:0]  req4, grant4, done4;
    logic [15:0] bound4, led4;
    logic        kick4, busy4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bound_scheduler #(.N_REQ(4), .STEP_DIV(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req1),
        .bound (bound1),
        .kick  (kick1),
        .grant (grant1),
        .done  (done1),
        .busy  (busy1),
        .LED   (led1)
    );

    bound_scheduler #(.N_REQ(4), .STEP_DIV(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req4),
        .bound (bound4),
        .kick  (kick4),
        .grant (grant4),
        .done  (done4),
        .busy  (busy4),
        .LED   (led4)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq31 [8];
        int          busy_low;
        int          waited;
        seq31 = '{16'h0001, 16'h0003, 16'h0007, 16'h000F,
                  16'h0007, 16'h0003, 16'h0001, 16'h0000};

        rst_n = 1'b0;
        req1 = '0; bound1 = '0; kick1 = 1'b0;
        req4 = '0; bound4 = '0; kick4 = 1'b0;
        cyc(); cyc();
        chk("rst_led1",   32'(led1),   32'h0);
        chk("rst_busy1",  32'(busy1),  32'h0);
        chk("rst_grant1", 32'(grant1), 32'h0);
        chk("rst_done1",  32'(done1),  32'h0);
        chk("rst_led4",   32'(led4),   32'h0);
        chk("rst_busy4",  32'(busy4),  32'h0);
        rst_n = 1'b1;
        cyc();

        // Single sweep of requester 2 with bound 3.
        bound1 = 16'h5372;
        req1   = 4'b0100;
        cyc();
        chk("t1_grant", 32'(grant1), 32'h4);
        chk("t1_busy",  32'(busy1),  32'h1);
        chk("t1_led0",  32'(led1),   32'h0);
        req1 = '0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("t1_led_%0d", i), 32'(led1), 32'(seq31[i]));
            chk($sformatf("t1_done_%0d", i), 32'(done1), (i == 7) ? 32'h4 : 32'h0);
            chk($sformatf("t1_grant_%0d", i), 32'(grant1), 32'h0);
        end
        chk("t1_busy_end", 32'(busy1), 32'h0);
        cyc();
        chk("t1_done_gone", 32'(done1), 32'h0);

        // All four request with bound 0 straight out of reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bound1 = 16'h0000;
        req1   = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("t2_grant_%0d", k), 32'(grant1), 32'(4'b0001 << k));
            req1[k] = 1'b0;
            cyc();
            chk($sformatf("t2_led1_%0d", k), 32'(led1), 32'h0001);
            chk($sformatf("t2_nodone_%0d", k), 32'(done1), 32'h0);
            cyc();
            chk($sformatf("t2_led0_%0d", k), 32'(led1), 32'h0000);
            chk($sformatf("t2_done_%0d", k), 32'(done1), 32'(4'b0001 << k));
            chk($sformatf("t2_gnt_off_%0d", k), 32'(grant1), 32'h0);
        end

        // Full bar with four-cycle steps.
        bound4 = 16'h000F;
        req4   = 4'b0001;
        cyc();
        chk("t3_grant", 32'(grant4), 32'h1);
        req4 = '0;
        busy_low = 0;
        for (int m = 1; m <= 63; m++) begin
            cyc();
            if (!busy4) busy_low++;
        end
        chk("t3_led_pre", 32'(led4), 32'h7FFF);
        cyc();
        chk("t3_led_full", 32'(led4), 32'hFFFF);
        for (int m = 65; m <= 127; m++) begin
            cyc();
            if (!busy4) busy_low++;
        end
        chk("t3_busy_low_cnt", 32'(busy_low), 32'h0);
        chk("t3_busy_127", 32'(busy4), 32'h1);
        chk("t3_nodone_127", 32'(done4), 32'h0);
        cyc();
        chk("t3_busy_128", 32'(busy4), 32'h0);
        chk("t3_done_128", 32'(done4), 32'h1);
        chk("t3_led_128",  32'(led4),  32'h0);

        // Reset in the middle of the fall.
        bound1 = 16'h0028;
        req1   = 4'b0001;
        cyc();
        chk("t4_grant", 32'(grant1), 32'h1);
        req1 = '0;
        for (int i = 0; i < 10; i++) cyc();
        chk("t4_led_ff", 32'(led1), 32'h00FF);
        rst_n = 1'b0;
        #1;
        chk("t4_led_rst",  32'(led1),  32'h0);
        chk("t4_busy_rst", 32'(busy1), 32'h0);
        req1 = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t4_rst_grant_%0d", i), 32'(grant1), 32'h0);
            chk($sformatf("t4_rst_done_%0d", i), 32'(done1), 32'h0);
        end
        rst_n = 1'b1;
        cyc();
        chk("t4_regrant", 32'(grant1), 32'h2);
        req1 = '0;
        for (int i = 0; i < 5; i++) cyc();
        chk("t4_nodone_early", 32'(done1), 32'h0);
        cyc();
        chk("t4_done", 32'(done1), 32'h2);
        chk("t4_led_end", 32'(led1), 32'h0);

        // Kick during UP (ignored) and at the fall step from level 3.
        bound1 = 16'h0005;
        req1   = 4'b0001;
        cyc();
        chk("t5_grant", 32'(grant1), 32'h1);
        req1 = '0;
        cyc();
        kick1 = 1'b1;
        cyc();
        kick1 = 1'b0;
        chk("t5_up_kick", 32'(led1), 32'h0003);
        for (int i = 0; i < 7; i++) cyc();
        chk("t5_led3", 32'(led1), 32'h0007);
        kick1 = 1'b1;
        cyc();
        kick1 = 1'b0;
`ifdef BOUND_SCHED_KICKBACK_EN
        chk("t5_kick_step", 32'(led1), 32'h000F);
        cyc();
        chk("t5_climb5", 32'(led1), 32'h001F);
        cyc();
        chk("t5_climb6", 32'(led1), 32'h003F);
        cyc();
        chk("t5_fall5", 32'(led1), 32'h001F);
`else
        chk("t5_kick_step", 32'(led1), 32'h0003);
        cyc();
        chk("t5_fall1", 32'(led1), 32'h0001);
`endif
        waited = 0;
        while (done1 == 4'b0 && waited < 40) begin
            cyc();
            waited++;
        end
        chk("t5_done", 32'(done1), 32'h1);
        chk("t5_busy_end", 32'(busy1), 32'h0);

        // Request arriving mid-sweep with its bound changing before grant.
        bound1 = 16'h0001;
        req1   = 4'b0001;
        cyc();
        chk("t6_grant0", 32'(grant1), 32'h1);
        req1 = '0;
        cyc();
        req1   = 4'b1010;
        bound1 = 16'h0031;
        cyc();
        req1   = 4'b0010;
        bound1 = 16'h0021;
        cyc();
        cyc();
        chk("t6_done0",    32'(done1),  32'h1);
        chk("t6_nogrant",  32'(grant1), 32'h0);
        cyc();
        chk("t6_grant1",   32'(grant1), 32'h2);
        req1 = '0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t6_peak", 32'(led1), 32'h0007);
        cyc();
        chk("t6_fall", 32'(led1), 32'h0003);
        cyc(); cyc();
        chk("t6_done1", 32'(done1), 32'h2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("t6_abandon_%0d", i), 32'(grant1), 32'h0);
        end
        chk("t6_idle", 32'(busy1), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
